// File: rtl/fft_bf_r2_stage_if.sv
// fft_bf_r2_stage_if
// Bundles the sample stream into a radix-2 butterfly stage and the result
// stream out of it.
//   in_valid        : stage-RAM read data valid this cycle
//   in_re / in_im   : sample components, signed DW bits
//   in_adr          : RAM address the sample was read from
//   tw_re / tw_im   : twiddle components, signed Q1.(TW-2)
//   out_valid       : result valid, write strobe for the next-stage RAM
//   out_re / out_im : butterfly result components, signed DW bits
//   out_adr         : write address for the result
// The master modport drives samples and observes results; the slave modport
// is the butterfly stage itself.
`timescale 1ns/1ps

interface fft_bf_r2_stage_if #(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int SIZE = 4
);
    logic                   in_valid;
    logic signed [DW-1:0]   in_re;
    logic signed [DW-1:0]   in_im;
    logic        [SIZE-1:0] in_adr;
    logic signed [TW-1:0]   tw_re;
    logic signed [TW-1:0]   tw_im;

    logic                   out_valid;
    logic signed [DW-1:0]   out_re;
    logic signed [DW-1:0]   out_im;
    logic        [SIZE-1:0] out_adr;

    modport master (
        output in_valid, in_re, in_im, in_adr, tw_re, tw_im,
        input  out_valid, out_re, out_im, out_adr
    );

    modport slave (
        input  in_valid, in_re, in_im, in_adr, tw_re, tw_im,
        output out_valid, out_re, out_im, out_adr
    );
endinterface

// File: rtl/fft_bf_r2_stage.sv
// fft_bf_r2_stage
// One radix-2 decimation-in-time butterfly stage. Samples arrive in pairs
// (A then B, any gap allowed); the stage computes S = A + W*B and
// D = A - W*B, scales each by 1/2 with rounding and saturation, and emits S
// (at A's address) then D (at B's address) on consecutive cycles.
// Pipeline: pair capture -> multiply -> add/sub/scale -> output register.
// B accepted on edge T gives S after edge T+3 and D after edge T+4.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sample/result interface (slave modport)
//   done_o : one-cycle pulse with the D of the last pair of a frame
`timescale 1ns/1ps

module fft_bf_r2_stage #(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int N    = 16,
    parameter int SIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fft_bf_r2_stage_if.slave       bus,
    output logic                   done_o
);

    localparam int PW  = DW + TW + 1;
    localparam int RW  = DW + 2;
    localparam int RND = 1 << (TW - 3);
    localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (DW - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(1 << (DW - 1)));
    localparam logic [SIZE-2:0]      LAST_PAIR = (SIZE - 1)'(N / 2 - 1);

    typedef enum logic {FIRST, SECOND} state_e;

    state_e                 state_q;

    logic signed [DW-1:0]   aHoldRe_q, aHoldIm_q;
    logic        [SIZE-1:0] aHoldAdr_q;

    logic                   s1Valid_q;
    logic signed [DW-1:0]   s1ARe_q, s1AIm_q, s1BRe_q, s1BIm_q;
    logic signed [TW-1:0]   s1WRe_q, s1WIm_q;
    logic        [SIZE-1:0] s1AAdr_q, s1BAdr_q;

    logic signed [PW-1:0]   prodRe_d, prodIm_d;

    logic                   s2Valid_q;
    logic signed [PW-1:0]   s2PRe_q, s2PIm_q;
    logic signed [DW-1:0]   s2ARe_q, s2AIm_q;
    logic        [SIZE-1:0] s2AAdr_q, s2BAdr_q;

    logic signed [PW-1:0]   pRndRe, pRndIm;
    logic signed [RW-1:0]   pRe, pIm, sumRe, sumIm, difRe, difIm;
    logic signed [DW-1:0]   sRe_d, sIm_d, dRe_d, dIm_d;

    logic                   s3Valid_q;
    logic signed [DW-1:0]   s3SRe_q, s3SIm_q, s3DRe_q, s3DIm_q;
    logic        [SIZE-1:0] s3AAdr_q, s3BAdr_q;

    logic                   outValid_q, dPend_q, done_q;
    logic signed [DW-1:0]   outRe_q, outIm_q;
    logic        [SIZE-1:0] outAdr_q;
    logic        [SIZE-2:0] pairCnt_q;

    // (x + 1) >>> 1, then clamp to the DW-bit signed range. The increment is
    // done one bit wider so it can never wrap.
    function automatic logic signed [DW-1:0] scaleSat(input logic signed [RW-1:0] x);
        logic signed [RW:0]   xInc;
        logic signed [RW-1:0] half;
        xInc = (RW + 1)'(x) + (RW + 1)'(1);
        half = RW'(xInc >>> 1);
        if (half > SAT_MAX)
            scaleSat = DW'(SAT_MAX);
        else if (half < SAT_MIN)
            scaleSat = DW'(SAT_MIN);
        else
            scaleSat = DW'(half);
    endfunction

    // Pairing FSM. A is parked in its own hold register and only copied into
    // the stage-1 pair registers together with B, so a following A can be
    // latched while the previous pair is still moving down the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FIRST;
            aHoldRe_q  <= '0;
            aHoldIm_q  <= '0;
            aHoldAdr_q <= '0;
            s1Valid_q  <= 1'b0;
            s1ARe_q    <= '0;
            s1AIm_q    <= '0;
            s1BRe_q    <= '0;
            s1BIm_q    <= '0;
            s1WRe_q    <= '0;
            s1WIm_q    <= '0;
            s1AAdr_q   <= '0;
            s1BAdr_q   <= '0;
        end else begin
            s1Valid_q <= 1'b0;
            if (bus.in_valid) begin
                case (state_q)
                    FIRST: begin
                        aHoldRe_q  <= bus.in_re;
                        aHoldIm_q  <= bus.in_im;
                        aHoldAdr_q <= bus.in_adr;
                        state_q    <= SECOND;
                    end
                    SECOND: begin
                        s1ARe_q   <= aHoldRe_q;
                        s1AIm_q   <= aHoldIm_q;
                        s1AAdr_q  <= aHoldAdr_q;
                        s1BRe_q   <= bus.in_re;
                        s1BIm_q   <= bus.in_im;
                        s1BAdr_q  <= bus.in_adr;
                        s1WRe_q   <= bus.tw_re;
                        s1WIm_q   <= bus.tw_im;
                        s1Valid_q <= 1'b1;
                        state_q   <= FIRST;
                    end
                    default: state_q <= FIRST;
                endcase
            end
        end
    end

    // Full-precision complex multiply W*B; operands are sign-extended to the
    // product width first so neither partial product nor the sum can wrap.
    always_comb begin
        prodRe_d = PW'(s1WRe_q) * PW'(s1BRe_q) - PW'(s1WIm_q) * PW'(s1BIm_q);
        prodIm_d = PW'(s1WRe_q) * PW'(s1BIm_q) + PW'(s1WIm_q) * PW'(s1BRe_q);
    end

    // Multiply stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q <= 1'b0;
            s2PRe_q   <= '0;
            s2PIm_q   <= '0;
            s2ARe_q   <= '0;
            s2AIm_q   <= '0;
            s2AAdr_q  <= '0;
            s2BAdr_q  <= '0;
        end else begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2PRe_q  <= prodRe_d;
                s2PIm_q  <= prodIm_d;
                s2ARe_q  <= s1ARe_q;
                s2AIm_q  <= s1AIm_q;
                s2AAdr_q <= s1AAdr_q;
                s2BAdr_q <= s1BAdr_q;
            end
        end
    end

    // Round the product back to sample scale (round-half-up, drop the Q
    // fraction bits), then butterfly add/sub at DW+2 bits and scale by 1/2.
    always_comb begin
        pRndRe = (s2PRe_q + PW'(RND)) >>> (TW - 2);
        pRndIm = (s2PIm_q + PW'(RND)) >>> (TW - 2);
        pRe    = RW'(pRndRe);
        pIm    = RW'(pRndIm);
        sumRe  = RW'(s2ARe_q) + pRe;
        sumIm  = RW'(s2AIm_q) + pIm;
        difRe  = RW'(s2ARe_q) - pRe;
        difIm  = RW'(s2AIm_q) - pIm;
        sRe_d  = scaleSat(sumRe);
        sIm_d  = scaleSat(sumIm);
        dRe_d  = scaleSat(difRe);
        dIm_d  = scaleSat(difIm);
    end

    // Add/sub/scale stage register. D waits here one extra cycle while S is
    // on the output; the next pair cannot reach this stage before then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3Valid_q <= 1'b0;
            s3SRe_q   <= '0;
            s3SIm_q   <= '0;
            s3DRe_q   <= '0;
            s3DIm_q   <= '0;
            s3AAdr_q  <= '0;
            s3BAdr_q  <= '0;
        end else begin
            s3Valid_q <= s2Valid_q;
            if (s2Valid_q) begin
                s3SRe_q  <= sRe_d;
                s3SIm_q  <= sIm_d;
                s3DRe_q  <= dRe_d;
                s3DIm_q  <= dIm_d;
                s3AAdr_q <= s2AAdr_q;
                s3BAdr_q <= s2BAdr_q;
            end
        end
    end

    // Output register: S in the cycle after stage 3 fills, D in the cycle
    // after that. Data and address hold when nothing is being written. The
    // pair counter advances on every D and flags the last pair of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outRe_q    <= '0;
            outIm_q    <= '0;
            outAdr_q   <= '0;
            dPend_q    <= 1'b0;
            done_q     <= 1'b0;
            pairCnt_q  <= '0;
        end else begin
            outValid_q <= 1'b0;
            done_q     <= 1'b0;
            if (s3Valid_q) begin
                outRe_q    <= s3SRe_q;
                outIm_q    <= s3SIm_q;
                outAdr_q   <= s3AAdr_q;
                outValid_q <= 1'b1;
                dPend_q    <= 1'b1;
            end else if (dPend_q) begin
                outRe_q    <= s3DRe_q;
                outIm_q    <= s3DIm_q;
                outAdr_q   <= s3BAdr_q;
                outValid_q <= 1'b1;
                dPend_q    <= 1'b0;
                if (pairCnt_q == LAST_PAIR) begin
                    pairCnt_q <= '0;
                    done_q    <= 1'b1;
                end else begin
                    pairCnt_q <= pairCnt_q + (SIZE - 1)'(1);
                end
            end
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_re    = outRe_q;
    assign bus.out_im    = outIm_q;
    assign bus.out_adr   = outAdr_q;
    assign done_o        = done_q;

endmodule
